// File: rtl/fifo_sync_if.sv
// fifo_sync_if: write-side valid/ready stream plus read-side pop/data/empty
// handshake for fifo_sync. The producer and consumer share the master modport;
// the FIFO itself uses the slave modport.
interface fifo_sync_if #(
    parameter int DATA_WIDTH = 32
) ();
    logic [DATA_WIDTH-1:0] up_bus;
    logic                  up_val;
    logic                  up_rdy;
    logic [DATA_WIDTH-1:0] fifo_data;
    logic                  fifo_empty;
    logic                  fifo_pop;

    modport master (
        output up_bus, up_val, fifo_pop,
        input  up_rdy, fifo_data, fifo_empty
    );

    modport slave (
        input  up_bus, up_val, fifo_pop,
        output up_rdy, fifo_data, fifo_empty
    );
endinterface

// File: rtl/fifo_sync.sv
// fifo_sync: single-clock FIFO with a registered read port (one-cycle latency).
// fifo_data holds its value whenever no effective pop occurs.
// Optional macro FIFO_COUNT_EN exposes the occupancy as the fifo_count port.
// count tracks words still stored, excluding the word already on fifo_data.
module fifo_sync #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
`ifdef FIFO_COUNT_EN
    output logic [ADDR_WIDTH:0] fifo_count,
`endif
    fifo_sync_if.slave        bus
);
    localparam logic [ADDR_WIDTH:0] DEPTH = (ADDR_WIDTH+1)'(2**ADDR_WIDTH);

    logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_WIDTH:0]   count_q, count_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  empty_q, empty_d;
    logic                  rdy_q, rdy_d;
    logic                  wr_en, pop_en;

    // Handshakes use only registered flags, so no input reaches an output combinationally.
    assign wr_en  = bus.up_val & rdy_q;
    assign pop_en = bus.fifo_pop & ~empty_q;

    // Next-state: pointers, occupancy, read data and flags derived from count_d.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        data_d   = data_q;
        if (wr_en)
            wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop_en) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
            data_d   = mem[rd_ptr_q];
        end
        count_d = count_q + {{ADDR_WIDTH{1'b0}}, wr_en} - {{ADDR_WIDTH{1'b0}}, pop_en};
        empty_d = (count_d == '0);
        rdy_d   = (count_d != DEPTH);
    end

    // Storage array is not reset; a write only happens while up_rdy is high.
    always_ff @(posedge clk) begin
        if (wr_en)
            mem[wr_ptr_q] <= bus.up_bus;
    end

    // Control and output registers; reset drops everything stored immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            data_q   <= '0;
            empty_q  <= 1'b1;
            rdy_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            data_q   <= data_d;
            empty_q  <= empty_d;
            rdy_q    <= rdy_d;
        end
    end

    assign bus.up_rdy     = rdy_q;
    assign bus.fifo_empty = empty_q;
    assign bus.fifo_data  = data_q;
`ifdef FIFO_COUNT_EN
    assign fifo_count     = count_q;
`endif
endmodule

// File: tb/tb_fifo_sync.sv
// tb_fifo_sync: directed vectors for fifo_sync with hand-computed expectations.
// Inputs change and outputs are sampled 1 ns after each rising edge.
module tb_fifo_sync;
    logic clk;
    logic rst_n;
    int   nvec;
    int   nerr;

    fifo_sync_if #(.DATA_WIDTH(32)) bus ();
`ifdef FIFO_COUNT_EN
    logic [4:0] fifo_count;
`endif

    fifo_sync #(.DATA_WIDTH(32), .ADDR_WIDTH(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
`ifdef FIFO_COUNT_EN
        .fifo_count (fifo_count),
`endif
        .bus        (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        nvec = 0;
        nerr = 0;
        rst_n = 1'b1;
        bus.up_bus = '0;
        bus.up_val = 1'b0;
        bus.fifo_pop = 1'b0;
        #2 rst_n = 1'b0;

        // Reset held for 3 cycles
        repeat (3) tick();
        chk("rst_empty", 32'(bus.fifo_empty), 32'd1);
        chk("rst_rdy",   32'(bus.up_rdy), 32'd0);
        chk("rst_data",  bus.fifo_data, 32'h0);
        rst_n = 1'b1;
        #1;
        chk("rel_rdy_before_edge", 32'(bus.up_rdy), 32'd0);
        tick();
        chk("rel_rdy_after_edge", 32'(bus.up_rdy), 32'd1);
        chk("rel_empty", 32'(bus.fifo_empty), 32'd1);

        // Fill to full with 0x00..0x0F
        for (int i = 0; i < 16; i++) begin
            bus.up_bus = 32'(i);
            bus.up_val = 1'b1;
            tick();
            if (i == 0) chk("fill_first_empty", 32'(bus.fifo_empty), 32'd0);
            if (i == 14) chk("fill_15_rdy", 32'(bus.up_rdy), 32'd1);
        end
        chk("full_rdy", 32'(bus.up_rdy), 32'd0);
        bus.up_bus = 32'hAA;
        tick();
        bus.up_val = 1'b0;
        chk("full_rdy_hold", 32'(bus.up_rdy), 32'd0);
        chk("full_empty", 32'(bus.fifo_empty), 32'd0);
`ifdef FIFO_COUNT_EN
        chk("full_count", 32'(fifo_count), 32'd16);
`endif

        // Drain in order, one-cycle latency
        for (int i = 0; i < 16; i++) begin
            bus.fifo_pop = 1'b1;
            tick();
            chk($sformatf("drain_%0d", i), bus.fifo_data, 32'(i));
            if (i == 0) chk("drain_rdy_rise", 32'(bus.up_rdy), 32'd1);
            if (i == 14) chk("drain_15_empty", 32'(bus.fifo_empty), 32'd0);
        end
        chk("drain_empty", 32'(bus.fifo_empty), 32'd1);
        tick();
        bus.fifo_pop = 1'b0;
        chk("pop_on_empty_data", bus.fifo_data, 32'h0F);
        chk("pop_on_empty_flag", 32'(bus.fifo_empty), 32'd1);

        // Stall hold: pop 0x05 then hold while writes continue
        bus.up_bus = 32'h05;
        bus.up_val = 1'b1;
        tick();
        bus.up_val = 1'b0;
        bus.fifo_pop = 1'b1;
        tick();
        bus.fifo_pop = 1'b0;
        chk("stall_pop", bus.fifo_data, 32'h05);
        for (int i = 0; i < 5; i++) begin
            bus.up_bus = 32'h10 + 32'(i);
            bus.up_val = 1'b1;
            tick();
            chk($sformatf("stall_hold_%0d", i), bus.fifo_data, 32'h05);
        end
        bus.up_val = 1'b0;

        // Reduce to count=1, then simultaneous write and pop
        for (int i = 0; i < 4; i++) begin
            bus.fifo_pop = 1'b1;
            tick();
            chk($sformatf("reduce_%0d", i), bus.fifo_data, 32'h10 + 32'(i));
        end
        bus.up_bus = 32'h20;
        bus.up_val = 1'b1;
        tick();
        bus.up_val = 1'b0;
        chk("sim1_data", bus.fifo_data, 32'h14);
        chk("sim1_empty", 32'(bus.fifo_empty), 32'd0);
`ifdef FIFO_COUNT_EN
        chk("sim1_count", 32'(fifo_count), 32'd1);
`endif
        tick();
        bus.fifo_pop = 1'b0;
        chk("sim1_next", bus.fifo_data, 32'h20);
        chk("sim1_then_empty", 32'(bus.fifo_empty), 32'd1);

        // Simultaneous write and pop at full
        for (int i = 0; i < 16; i++) begin
            bus.up_bus = 32'h30 + 32'(i);
            bus.up_val = 1'b1;
            tick();
        end
        chk("full2_rdy", 32'(bus.up_rdy), 32'd0);
        bus.up_bus = 32'h99;
        bus.fifo_pop = 1'b1;
        tick();
        bus.up_val = 1'b0;
        chk("full2_pop_data", bus.fifo_data, 32'h30);
        chk("full2_rdy_rise", 32'(bus.up_rdy), 32'd1);
        for (int i = 1; i < 16; i++) begin
            tick();
            chk($sformatf("full2_drain_%0d", i), bus.fifo_data, 32'h30 + 32'(i));
        end
        bus.fifo_pop = 1'b0;
        chk("full2_no_0x99", 32'(bus.fifo_empty), 32'd1);

        // Stream 40 words through with pop every cycle (wraps the pointers)
        for (int i = 0; i <= 40; i++) begin
            bus.up_val = (i < 40);
            bus.up_bus = 32'h100 + 32'(i);
            bus.fifo_pop = 1'b1;
            tick();
            if (i >= 1) chk($sformatf("wrap_%0d", i - 1), bus.fifo_data, 32'h100 + 32'(i - 1));
        end
        bus.up_val = 1'b0;
        bus.fifo_pop = 1'b0;
        chk("wrap_empty", 32'(bus.fifo_empty), 32'd1);

        // Async reset mid-stream with count=7
        for (int i = 0; i < 7; i++) begin
            bus.up_bus = 32'h50 + 32'(i);
            bus.up_val = 1'b1;
            tick();
        end
        bus.up_val = 1'b0;
`ifdef FIFO_COUNT_EN
        chk("pre_arst_count", 32'(fifo_count), 32'd7);
`endif
        #2 rst_n = 1'b0;
        #1;
        chk("arst_empty", 32'(bus.fifo_empty), 32'd1);
        chk("arst_rdy", 32'(bus.up_rdy), 32'd0);
        chk("arst_data", bus.fifo_data, 32'h0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("arst_rel_rdy", 32'(bus.up_rdy), 32'd1);
        bus.up_bus = 32'h3C;
        bus.up_val = 1'b1;
        tick();
        bus.up_val = 1'b0;
        bus.fifo_pop = 1'b1;
        tick();
        bus.fifo_pop = 1'b0;
        chk("arst_first_word", bus.fifo_data, 32'h3C);
        chk("arst_after_empty", 32'(bus.fifo_empty), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule

// File: doc/fifo_sync.md
Name: fifo_sync

Overview:
- Single-clock synchronous FIFO with a registered (one-cycle read latency) output port.
- Sits directly upstream of the skid fall-through stage: it drives fifo_data/fifo_empty and consumes fifo_pop.
- The write side is a valid/ready stream from the producing pipeline.
- Output data is held stable whenever no pop occurs. The downstream stage depends on this.

Parameters:
- DATA_WIDTH, 32, width of each stored word.
- ADDR_WIDTH, 4, log2 of depth; DEPTH = 2**ADDR_WIDTH entries (default 16).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- up_bus  input  DATA_WIDTH  write data.
- up_val  input  1  write data valid.
- up_rdy  output  1  FIFO can accept a word (registered, = not full).
- fifo_data  output  DATA_WIDTH  registered read data.
- fifo_empty  output  1  registered empty flag.
- fifo_pop  input  1  read request.

Behaviour:
- Reset: one clock; reset is asynchronous and active-low.
  - While rst_n=0: rd_ptr=0, wr_ptr=0, count=0, fifo_empty=1, up_rdy=0, fifo_data=0.
  - up_rdy rises on the first clk edge after rst_n deasserts.
  - Memory contents are not reset.
  - Reset asserted mid-operation discards all stored words immediately; no partial write or read completes.
- Write:
  - Accepted on an edge where up_val & up_rdy.
  - mem[wr_ptr] <= up_bus; wr_ptr increments, wrapping from DEPTH-1 to 0.
  - up_val while up_rdy=0 is ignored; the producer must hold the word.
- Read:
  - Effective pop = fifo_pop & ~fifo_empty, sampled at an edge.
  - On an effective pop: fifo_data <= mem[rd_ptr], and rd_ptr increments with wrap.
  - Read latency is one cycle: the popped word is visible on fifo_data in the cycle after the pop.
  - fifo_pop while fifo_empty=1 is ignored: fifo_data, pointers and count unchanged.
  - No pop: fifo_data holds its value exactly.
- Occupancy:
  - count is ADDR_WIDTH+1 bits, range 0..DEPTH.
  - Update rule: count_next = count + write - pop_eff.
- Flags (both registered, derived from count_next):
  - fifo_empty = (count_next==0).
  - up_rdy = (count_next!=DEPTH).
  - A written word can be popped on the edge after its write edge (write-to-empty-deassert latency 1).
  - fifo_empty never rises except on an effective pop.
- Simultaneous write and pop:
  - Both occur; count unchanged.
  - When full, up_rdy=0, so only the pop occurs; up_rdy rises next cycle.
  - When empty, the pop is ignored and the write occurs; fifo_empty falls next cycle.
  - Write and read never target the same entry in the same cycle while the read is valid.
- No combinational path from up_val or fifo_pop to any output.

Optional Feature:
- Macro: FIFO_COUNT_EN.
- Defined:
  - Adds output port fifo_count [ADDR_WIDTH:0], equal to the registered count (words stored, excluding the word already presented on fifo_data).
  - Resets to 0 and updates on the same edge as the flags.
- Undefined: port absent; count remains internal only; all other behaviour identical.

Test Plan:
- Reset/ready: hold rst_n=0 for 3 cycles, then release -> fifo_empty=1, up_rdy=0 during reset, up_rdy=1 one edge after release, fifo_data=0.
- Fill to full: write 0x00..0x0F with fifo_pop=0 -> up_rdy=0 after the 16th accept; a 17th write (0xAA) is not stored; fifo_empty=0.
- Drain order and latency: from full, pop every cycle -> fifo_data = 0x00..0x0F one cycle after each pop; fifo_empty=1 after the 16th pop; a 17th pop leaves fifo_data=0x0F.
- Stall hold: pop 0x05, then fifo_pop=0 for 5 cycles with writes ongoing -> fifo_data stays 0x05 throughout.
- Simultaneous write and pop at count=1, and at full -> count stays 1; at full, only the pop happens and up_rdy rises the next cycle; wrap past index 15 preserves order (write 40 words, read 40 words, sequence matches).
- Async reset mid-stream: drop rst_n between edges with count=7 -> fifo_empty=1 and up_rdy=0 immediately, no clock needed; after release, the first write of 0x3C then a pop yields fifo_data=0x3C.
